// File: rtl/multdiv_pkg.sv
// Shared constants and helpers for the sequential multiply/divide unit.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package multdiv_pkg;

   // Legacy-compatible state encoding
   typedef logic [1:0] stateT;
   localparam stateT IDLE = 2'd0;
   localparam stateT MULT = 2'd1;
   localparam stateT DIV  = 2'd2;
   localparam stateT DONE = 2'd3;

   localparam int MULT_ITERS = 16;   // radix-4 Booth: two multiplier bits per step
   localparam int DIV_ITERS  = 32;   // restoring divide: one quotient bit per step
   localparam int CNT_W      = 6;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   // Magnitude of a two's complement word; INT_MIN maps to 0x80000000 read as unsigned
   function automatic logic [31:0] absVal(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: three multiplier bits select 0, +-M or +-2M.
// Latency: combinational.
// Backpressure: none.
module booth_recoder
   import multdiv_pkg::*;
(
   input  logic [2:0]  boothBits,
   input  logic [31:0] multiplicand,
   output logic [32:0] partialProduct
);

   logic [32:0] mOne;
   logic [32:0] mTwo;

   assign mOne = {multiplicand[31], multiplicand};
   assign mTwo = {multiplicand, 1'b0};

   // Select the signed multiple of the multiplicand for this digit
   always_comb begin
      partialProduct = '0;
      case (boothBits)
         3'b001, 3'b010: partialProduct = mOne;
         3'b011:         partialProduct = mTwo;
         3'b100:         partialProduct = ~mTwo + 33'd1;
         3'b101, 3'b110: partialProduct = ~mOne + 33'd1;
         default:        partialProduct = '0;
      endcase
   end

endmodule

// File: rtl/seq_multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth) and divide (restoring on magnitudes).
// Latency: multiply 17 edges, divide 33 edges from the start edge to the one-cycle RDY pulse.
// Backpressure: none; a new start at any time aborts and restarts, result held until next completion.
module seq_multdiv #(
   parameter int MULT_ITERS = multdiv_pkg::MULT_ITERS,
   parameter int DIV_ITERS  = multdiv_pkg::DIV_ITERS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);
   import multdiv_pkg::*;

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS);

   stateT            state;
   logic [CNT_W-1:0] cnt;
   // Multiply: {upper, lower} is the 65-bit product register, guard is the Booth guard bit.
   // Divide: upper is the partial remainder, lower the dividend/quotient shift register.
   logic [32:0]      upper;
   logic [31:0]      lower;
   logic             guard;
   logic [31:0]      mcand;      // multiplicand, or divisor magnitude
   logic             quotNeg;
   logic             divZero;
   logic             divOvf;

   logic        startAny;
   logic        multFinish;
   logic        divFinish;
   logic [32:0] pp;
   logic        ppTop;
   logic [32:0] remShift;
   logic [34:0] addA;
   logic [34:0] addB;
   logic        addCin;
   logic [34:0] addSum;
   logic [32:0] prodHigh;

   assign startAny   = ctrl_MULT | ctrl_DIV;
   assign multFinish = (state == MULT) && (cnt == MULT_LAST) && !startAny;
   assign divFinish  = (state == DIV)  && (cnt == DIV_LAST)  && !startAny;

   booth_recoder uRecoder (
      .boothBits      ({lower[1:0], guard}),
      .multiplicand   (mcand),
      .partialProduct (pp)
   );

   // -2 * INT_MIN is +2^32, which wraps negative in 33 bits; its true sign bit is 0
   assign ppTop = (({lower[1:0], guard} == 3'b100) && (mcand == INT_MIN)) ? 1'b0 : pp[32];

   // Partial remainder shifted left with the next dividend bit; always below 2^32
   assign remShift = {upper[31:0], lower[31]};

   // Shared adder: Booth accumulate in MULT, trial subtract of the divisor in DIV
   always_comb begin
      addA   = {upper[32], upper[32], upper};
      addB   = {ppTop, ppTop, pp};
      addCin = 1'b0;
      if (state == DIV) begin
         addA   = {2'b00, remShift};
         addB   = {3'b111, ~mcand};
         addCin = 1'b1;
      end
   end

   assign addSum   = addA + addB + {34'd0, addCin};
   assign prodHigh = {upper[31:0], lower[31]};

   // Sequencer and working registers: start/abort, iterate, then one cycle in DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         upper   <= '0;
         lower   <= '0;
         guard   <= 1'b0;
         mcand   <= '0;
         quotNeg <= 1'b0;
         divZero <= 1'b0;
         divOvf  <= 1'b0;
      end else if (ctrl_MULT) begin
         state <= MULT;
         cnt   <= '0;
         upper <= '0;
         lower <= data_operandB;
         guard <= 1'b0;
         mcand <= data_operandA;
      end else if (ctrl_DIV) begin
         state   <= DIV;
         cnt     <= '0;
         upper   <= '0;
         lower   <= absVal(data_operandA);
         guard   <= 1'b0;
         mcand   <= absVal(data_operandB);
         quotNeg <= data_operandA[31] ^ data_operandB[31];
         divZero <= (data_operandB == 32'd0);
         divOvf  <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
      end else begin
         case (state)
            MULT: begin
               if (cnt == MULT_LAST) begin
                  state <= DONE;
               end else begin
                  upper <= addSum[34:2];
                  lower <= {addSum[1:0], lower[31:2]};
                  guard <= lower[1];
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            DIV: begin
               if (cnt == DIV_LAST) begin
                  state <= DONE;
               end else begin
                  if (addSum[34]) begin
                     upper <= remShift;
                     lower <= {lower[30:0], 1'b0};
                  end else begin
                     upper <= addSum[32:0];
                     lower <= {lower[30:0], 1'b1};
                  end
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Result registers load only on entry to DONE; RDY is high for that single cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= multFinish | divFinish;
         if (multFinish) begin
            data_result    <= lower;
            data_exception <= !((&prodHigh) || !(|prodHigh));
         end else if (divFinish) begin
            if (divZero) begin
               data_result    <= '0;
               data_exception <= 1'b1;
            end else if (divOvf) begin
               data_result    <= INT_MIN;
               data_exception <= 1'b1;
            end else begin
               data_result    <= quotNeg ? (~lower + 32'd1) : lower;
               data_exception <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_multdiv.sv
// Directed bench for seq_multdiv: latency, results, exceptions, abort, priority, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_multdiv;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int checks = 0;
   int errors = 0;

   seq_multdiv dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   // Pulse a start for one edge (edge N), then watch `window` further edges.
   // firstRdy is the k of the first edge N+k after which RDY is seen high (-1 if never).
   task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int window, output int firstRdy, output int nRdy,
                         output logic [31:0] res, output logic exc);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = m;
      ctrl_DIV = d;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h0BAD_F00D;
      firstRdy = -1;
      nRdy = 0;
      res = 'x;
      exc = 1'bx;
      for (int k = 1; k <= window; k++) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) begin
            if (firstRdy < 0) begin
               firstRdy = k;
               res = data_result;
               exc = data_exception;
            end
            nRdy++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
      checks++;
      if (data_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", data_result); end
      checks++;
      if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", data_exception); end
      reset = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL idle_rdy got %b want 0", data_resultRDY); end
   endtask

   task automatic test_mult();
      logic [31:0] ta [9] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_2345};
      logic [31:0] tb [9] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
                              32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h0000_0100};
      logic [31:0] tr [9] = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'h0, 32'h1,
                              32'h19, 32'h0, 32'h8000_0000, 32'h0123_4500};
      logic        te [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int firstRdy, nRdy;
      logic [31:0] res;
      logic exc;
      for (int i = 0; i < 9; i++) begin
         run_op(1'b1, 1'b0, ta[i], tb[i], 20, firstRdy, nRdy, res, exc);
         checks++;
         if (firstRdy !== 17) begin errors++; $display("FAIL mult%0d_latency got %0d want 17", i, firstRdy); end
         checks++;
         if (nRdy !== 1) begin errors++; $display("FAIL mult%0d_rdy_count got %0d want 1", i, nRdy); end
         checks++;
         if (res !== tr[i]) begin errors++; $display("FAIL mult%0d_result got %h want %h", i, res, tr[i]); end
         checks++;
         if (exc !== te[i]) begin errors++; $display("FAIL mult%0d_exc got %b want %b", i, exc, te[i]); end
         checks++;
         if (data_result !== tr[i]) begin errors++; $display("FAIL mult%0d_hold got %h want %h", i, data_result, tr[i]); end
      end
   endtask

   task automatic test_div();
      logic [31:0] ta [11] = '{32'hFFFF_FF9C, 32'd100, 32'd100, 32'hFFFF_FF9C, 32'd5, 32'h8000_0000,
                               32'h8000_0000, 32'h8000_0000, 32'd3, 32'h7FFF_FFFF, 32'd0};
      logic [31:0] tb [11] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF,
                               32'd1, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd0};
      logic [31:0] tr [11] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'hE, 32'hE, 32'h0, 32'h8000_0000,
                               32'h8000_0000, 32'h1, 32'h0, 32'h3FFF_FFFF, 32'h0};
      logic        te [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int firstRdy, nRdy;
      logic [31:0] res;
      logic exc;
      for (int i = 0; i < 11; i++) begin
         run_op(1'b0, 1'b1, ta[i], tb[i], 36, firstRdy, nRdy, res, exc);
         checks++;
         if (firstRdy !== 33) begin errors++; $display("FAIL div%0d_latency got %0d want 33", i, firstRdy); end
         checks++;
         if (nRdy !== 1) begin errors++; $display("FAIL div%0d_rdy_count got %0d want 1", i, nRdy); end
         checks++;
         if (res !== tr[i]) begin errors++; $display("FAIL div%0d_result got %h want %h", i, res, tr[i]); end
         checks++;
         if (exc !== te[i]) begin errors++; $display("FAIL div%0d_exc got %b want %b", i, exc, te[i]); end
      end
   endtask

   // Divide at N aborted by a 6x7 multiply at N+10; previous result must hold meanwhile
   task automatic test_restart();
      logic [31:0] prevRes;
      int hits = 0;
      int firstHit = -1;
      logic [31:0] hitRes = 'x;
      logic hitExc = 1'bx;
      prevRes = data_result;
      @(negedge clock);
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV = 1'b1;
      @(posedge clock);
      for (int k = 0; k <= 45; k++) begin
         @(negedge clock);
         ctrl_DIV = 1'b0;
         ctrl_MULT = 1'b0;
         if (k == 9) begin
            data_operandA = 32'd6;
            data_operandB = 32'd7;
            ctrl_MULT = 1'b1;
         end
         if (k == 20) begin
            checks++;
            if (data_result !== prevRes) begin errors++; $display("FAIL abort_hold got %h want %h", data_result, prevRes); end
         end
         if (data_resultRDY === 1'b1) begin
            hits++;
            if (firstHit < 0) begin firstHit = k; hitRes = data_result; hitExc = data_exception; end
         end
      end
      checks++;
      if (hits !== 1) begin errors++; $display("FAIL restart_rdy_count got %0d want 1", hits); end
      checks++;
      if (firstHit !== 27) begin errors++; $display("FAIL restart_latency got %0d want 27", firstHit); end
      checks++;
      if (hitRes !== 32'd42) begin errors++; $display("FAIL restart_result got %h want 0000002a", hitRes); end
      checks++;
      if (hitExc !== 1'b0) begin errors++; $display("FAIL restart_exc got %b want 0", hitExc); end
   endtask

   task automatic test_priority();
      int firstRdy, nRdy;
      logic [31:0] res;
      logic exc;
      run_op(1'b1, 1'b1, 32'hFFFF_FFF7, 32'd4, 36, firstRdy, nRdy, res, exc);
      checks++;
      if (firstRdy !== 17) begin errors++; $display("FAIL prio_latency got %0d want 17", firstRdy); end
      checks++;
      if (nRdy !== 1) begin errors++; $display("FAIL prio_rdy_count got %0d want 1", nRdy); end
      checks++;
      if (res !== 32'hFFFF_FFDC) begin errors++; $display("FAIL prio_result got %h want ffffffdc", res); end
   endtask

   // Start honoured while in DONE: RDY still drops, next RDY 17 edges later
   task automatic test_back_to_back();
      int hitK [$];
      logic [31:0] hitRes [$];
      @(negedge clock);
      data_operandA = 32'd2;
      data_operandB = 32'd3;
      ctrl_MULT = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         ctrl_MULT = 1'b0;
         if (data_resultRDY === 1'b1) begin
            hitK.push_back(k);
            hitRes.push_back(data_result);
         end
         if (k == 17) begin
            data_operandA = 32'd4;
            data_operandB = 32'd5;
            ctrl_MULT = 1'b1;
         end
      end
      checks++;
      if (hitK.size() !== 2) begin errors++; $display("FAIL b2b_rdy_count got %0d want 2", hitK.size()); end
      if (hitK.size() >= 2) begin
         checks++;
         if (hitK[0] !== 17 || hitK[1] !== 35) begin
            errors++; $display("FAIL b2b_latency got %0d,%0d want 17,35", hitK[0], hitK[1]);
         end
         checks++;
         if (hitRes[0] !== 32'd6 || hitRes[1] !== 32'd20) begin
            errors++; $display("FAIL b2b_result got %h,%h want 00000006,00000014", hitRes[0], hitRes[1]);
         end
      end
   endtask

   task automatic test_reset_midop();
      int hits = 0;
      int firstRdy, nRdy;
      logic [31:0] res;
      logic exc;
      // leave a nonzero result/exception behind so the reset clearing is visible
      run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0003_0000, 20, firstRdy, nRdy, res, exc);
      @(negedge clock);
      data_operandA = 32'd5;
      data_operandB = 32'd9;
      ctrl_MULT = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      repeat (7) @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL rst_mid_rdy got %b want 0", data_resultRDY); end
      checks++;
      if (data_result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 00000000", data_result); end
      checks++;
      if (data_exception !== 1'b0) begin errors++; $display("FAIL rst_mid_exc got %b want 0", data_exception); end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) hits++;
      end
      checks++;
      if (hits !== 0) begin errors++; $display("FAIL rst_release_rdy got %0d pulses want 0", hits); end
      run_op(1'b1, 1'b0, 32'd3, 32'd3, 20, firstRdy, nRdy, res, exc);
      checks++;
      if (firstRdy !== 17) begin errors++; $display("FAIL rst_fresh_latency got %0d want 17", firstRdy); end
      checks++;
      if (res !== 32'd9) begin errors++; $display("FAIL rst_fresh_result got %h want 00000009", res); end
      checks++;
      if (exc !== 1'b0) begin errors++; $display("FAIL rst_fresh_exc got %b want 0", exc); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_restart();
      test_priority();
      test_back_to_back();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_multdiv.md
# seq_multdiv

Iterative signed 32-bit multiply/divide unit that sits directly beside the execute stage. The execute stage pulses a start, freezes its pipeline latches, and consumes the result on the single cycle that `data_resultRDY` is high. Multiply is a radix-4 Booth multiply over 16 iterations; divide is a restoring divide on magnitudes over 32 iterations. Both have fixed, data-independent latency.

## Interface
- `MULT_ITERS`, default 16: Booth radix-4 iterations (32 / 2).
- `DIV_ITERS`, default 32: restoring-divide iterations.
- `clock`  in  1  Single clock. All state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-low. Low forces every register to its reset value immediately.
- `data_operandA`  in  32  Multiplicand or dividend (two's complement).
- `data_operandB`  in  32  Multiplier or divisor (two's complement).
- `ctrl_MULT`  in  1  Start multiply. Sampled on the edge.
- `ctrl_DIV`  in  1  Start divide. Sampled on the edge.
- `data_result`  out  32  Low 32 bits of the product, or the quotient.
- `data_exception`  out  1  Overflow or divide-by-zero flag, valid with `data_result`.
- `data_resultRDY`  out  1  One-cycle pulse: `data_result` and `data_exception` are valid.

## Operation
- States: IDLE, MULT, DIV, DONE. Reset puts the unit in IDLE.
- Reset values: `data_result`=0, `data_exception`=0, `data_resultRDY`=0. The counter and all working registers are 0.
- **Start**
  - A start edge (`ctrl_MULT` or `ctrl_DIV` sampled high) in any state latches both operands, clears the counter and enters MULT or DIV.
  - A start edge in MULT or DIV aborts the current operation and restarts it. No RDY is issued for the aborted operation.
  - If `ctrl_MULT` and `ctrl_DIV` are both high, multiply wins.
- **Multiply (MULT)**
  - Working register is 65 bits: {upper 33, multiplier 32}, plus a Booth guard bit.
  - Each edge: recode 3 bits into {0, ±M, ±2M}, add into the upper 33 bits (sign-extended), then arithmetic-shift right by 2.
  - After `MULT_ITERS` edges, go to DONE.
- **Divide (DIV)**
  - At start, latch |A|, |B|, and sign = A[31]^B[31].
  - Each edge: shift {R, Q} left by 1, trial-subtract |B|; if the difference is non-negative, keep it and set Q[0]=1.
  - After `DIV_ITERS` edges, go to DONE.
- **Result register.** Written on the transition into DONE:
  - Multiply: result = product[31:0]. Exception = 1 if product[63:31] is not all-equal bits (the product does not fit in 32 bits).
  - Divide, B=0: result = 0, exception = 1.
  - Divide, A=0x80000000 and B=0xFFFFFFFF: result = 0x80000000, exception = 1.
  - Other divides: result = sign ? −Q : Q, truncated toward zero. Exception = 0.
  - Divide-by-zero still takes full DIV latency.
- **DONE.** Asserts `data_resultRDY` for exactly one cycle, then returns to IDLE. A start edge in DONE is honoured; RDY still drops after that cycle.
- **Hold.** `data_result` and `data_exception` hold their value until the next DONE entry or reset. Aborts do not disturb them.
- `ctrl_*` held high continuously restarts the unit on every edge. The requester must pulse for exactly one edge.

## Timing
- Start sampled at edge N.
- Multiply: DONE entered at edge N+`MULT_ITERS`+1 = N+17. RDY is high from that edge until edge N+18.
- Divide: DONE entered at edge N+33. RDY is high until edge N+34.
- Operands only need to be stable at edge N.
- Reset asserted mid-operation: the unit returns to IDLE immediately and RDY is low. Reset released: IDLE, waiting for a start.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `multdiv_pkg`:
  - State enum: IDLE, MULT, DIV, DONE.
  - `MULT_ITERS`, `DIV_ITERS`, counter width (6 bits).
  - Constant INT_MIN = 0x80000000.
- One sub-module, `booth_recoder`: combinational. Input is 3 bits plus a 32-bit multiplicand; output is a 33-bit signed partial product (0, ±M, ±2M).
- Top holds the FSM, the 6-bit counter, the shared 33-bit adder/subtractor, and the result/exception/RDY registers.

## Test plan
- **Multiply.** A=7, B=0xFFFFFFFD, `ctrl_MULT` pulsed at edge N → RDY high only during cycle N+17..N+18, result=0xFFFFFFEB (−21), exception=0.
- **Multiply overflow.** A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. Also A=0x80000000, B=1 → 0x80000000, exception=0.
- **Signed divide.** A=0xFFFFFF9C (−100), B=7, `ctrl_DIV` at N → RDY at N+33, result=0xFFFFFFF2 (−14), exception=0. Also A=100, B=−7 → 0xFFFFFFF2.
- **Divide by zero and INT_MIN/−1.**
  - A=5, B=0 → result=0, exception=1, RDY at N+33.
  - A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1.
- **Restart and priority.**
  - Divide started at N, multiply 6×7 pulsed at N+10 → no RDY near N+33. Single RDY at N+27 with result=42.
  - `ctrl_MULT` and `ctrl_DIV` high together → multiply latency and result.
- **Reset.** `reset` driven low at N+8 of a multiply → RDY, result and exception are 0 immediately. No RDY after release. A fresh 3×3 after release → 9 at +17.
